mc_controller: RTL
==================

Name: mc_controller

Overview:
Multicycle control unit for the ARM-subset processor: a state machine that sequences one shared ALU, a unified instruction/data memory port and the register file over 3–5 cycles per instruction. It holds the NZCV flag register, evaluates condition codes, and gates all architectural write enables. It drives the multicycle datapath in place of the single-cycle decoder/condition-logic pair.

Parameters:
STATE_W, 4, width of the state register; must be at least 4, and extra bits are tied to zero.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
Instr  in  20  Instr[31:12] from the instruction register
ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in execute cycles
PCWrite  out  1  PC register enable
MemWrite  out  1  memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut/Result
RegSrc  out  2  register-read address selects
ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC
ALUSrcB  out  2  ALU B select: 00 = Rm, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ImmSrc  out  2  extender mode
ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- Field decode: Op = Instr[27:26], Funct = Instr[25:20], cmd = Instr[24:21], S = Instr[20], L = Instr[20], I = Instr[25], Cond = Instr[31:28].
- Combinational outputs: ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01).
- States and transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR if Op=01; EXECUTER if Op=00 and I=0; EXECUTEI if Op=00 and I=1; BRANCH if Op=10; UNKNOWN if Op=11.
  - MEMADR → MEMREAD if L=1, else MEMWRITE.
  - MEMREAD → MEMWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
- Per-state outputs (unlisted selects default to 0, unlisted enables to 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 unconditionally.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1.
  - MEMWRITE: AdrSrc=1, MemW.
  - MEMWB: ResultSrc=01, RegW.
  - EXECUTER: ALUSrcB=00, ALU decode.
  - EXECUTEI: ALUSrcB=01, ALU decode.
  - ALUWB: ResultSrc=00, RegW.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch.
  - UNKNOWN: all enables 0.
- ALU decode (execute states only):
  - cmd 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR.
  - Any other cmd → ADD with FlagW=00.
  - FlagW[1] = S. FlagW[0] = S & (ADD|SUB). Outside execute states FlagW=00.
- Condition evaluation:
  - CondEx is combinational from Cond and the stored flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 → 0.
  - CondExL is a register loaded with CondEx at the end of DECODE and held until the next DECODE.
- Flag register:
  - Flags[3:2] (N,Z) load ALUFlags[3:2] when FlagW[1] & CondExL.
  - Flags[1:0] (C,V) load ALUFlags[1:0] when FlagW[0] & CondExL.
  - Loads occur at the clock edge ending EXECUTER/EXECUTEI.
- Gated enables: RegWrite = RegW & CondExL. MemWrite = MemW & CondExL. PCWrite = (state==FETCH) | (Branch & CondExL).
- Latency: LDR 5 cycles, STR 4, data-processing 4, B 3, undefined 3. A failed condition still walks the full state path, with all writes and flag updates suppressed.
- Reset (reset=0, asynchronous):
  - state=FETCH, Flags=0000, CondExL=0.
  - While reset is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0; the remaining selects show their FETCH values.
  - The first FETCH executes in the first cycle after reset deasserts.
  - Reset mid-instruction aborts it with no further writes.
- No X propagation: all state-register bit patterns outside the defined states are treated as UNKNOWN.

Test Plan:
- Reset release, then ADD R1,R2,R3 (Instr=E0821 with cond AL) → 4 cycles: FETCH (PCWrite=1, IRWrite=1), DECODE, EXECUTER (ALUControl=00), ALUWB (RegWrite=1); Flags unchanged.
- SUBS producing ALUFlags=0100 in EXECUTER → Flags=0100. A following BEQ → BRANCH with PCWrite=1, 3 cycles. A following BNE → PCWrite=0 in BRANCH.
- LDR (Op=01, L=1) → sequence FETCH/DECODE/MEMADR/MEMREAD/MEMWB: AdrSrc=1 in MEMREAD, ResultSrc=01 and RegWrite=1 in MEMWB. STR (L=0) → MemWrite=1 in MEMWRITE only, 4 cycles.
- Conditional failure: Flags=0000, ADDEQ with S=1 → RegWrite=0 in ALUWB and Flags remain 0000. Cond=1111 → no writes.
- Op=11 → DECODE→UNKNOWN→FETCH with all enables 0. ORRS with ALUFlags=1011 → Flags=1000 (C,V not written for logical ops).
- Assert reset during MEMWRITE → MemWrite drops to 0 immediately (asynchronous), state=FETCH, Flags=0000. On release, first cycle shows PCWrite=1.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller sits on the slave side: it reads the instruction fields
// and ALU flags and drives every datapath select and write enable.
interface mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM-subset processor.
// Sequences a shared ALU, unified memory port and register file over
// 3-5 cycles per instruction, owns the NZCV flags and the condition
// check, and gates every architectural write with the latched condition.
module mc_controller #(
  parameter int STATE_W = 4
) (
  input logic            clk,
  input logic            reset,
  mc_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  // Raw state bits; any pattern outside the defined states decodes as UNKNOWN.
  logic [STATE_W-1:0] state_r;
  state_e             state_s;
  state_e             next_s;

  // Instruction fields
  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [3:0] cmd_s;
  logic       s_s;
  logic       l_s;
  logic       i_s;
  logic       unused_rd_rn_s;

  assign cond_s         = bus.Instr[19:16];
  assign op_s           = bus.Instr[15:14];
  assign i_s            = bus.Instr[13];
  assign cmd_s          = bus.Instr[12:9];
  assign s_s            = bus.Instr[8];
  assign l_s            = bus.Instr[8];
  assign unused_rd_rn_s = ^bus.Instr[7:0];

  // Architectural and pipeline-control state
  logic [3:0] flags_r;
  logic       condexl_r;
  logic       condex_s;

  // Per-state controls before condition gating
  logic       pcw_fetch_s;
  logic       branch_s;
  logic       regw_s;
  logic       memw_s;
  logic       irwrite_s;
  logic       adrsrc_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] resultsrc_s;
  logic [1:0] aluctl_s;
  logic [1:0] flagw_s;

  // ALU decode results for execute states
  logic [1:0] alu_dec_s;
  logic [1:0] flagw_dec_s;

  // Map raw state bits onto a defined state, illegal patterns fall to UNKNOWN
  always_comb begin
    state_s = S_UNKNOWN;
    case (state_r)
      STATE_W'(S_FETCH):    state_s = S_FETCH;
      STATE_W'(S_DECODE):   state_s = S_DECODE;
      STATE_W'(S_MEMADR):   state_s = S_MEMADR;
      STATE_W'(S_MEMREAD):  state_s = S_MEMREAD;
      STATE_W'(S_MEMWB):    state_s = S_MEMWB;
      STATE_W'(S_MEMWRITE): state_s = S_MEMWRITE;
      STATE_W'(S_EXECUTER): state_s = S_EXECUTER;
      STATE_W'(S_EXECUTEI): state_s = S_EXECUTEI;
      STATE_W'(S_ALUWB):    state_s = S_ALUWB;
      STATE_W'(S_BRANCH):   state_s = S_BRANCH;
      default:              state_s = S_UNKNOWN;
    endcase
  end

  // State register; reset returns to FETCH with upper bits cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= STATE_W'(S_FETCH);
    end else begin
      state_r <= STATE_W'(next_s);
    end
  end

  // Data-processing ALU operation and flag-write decode from cmd/S
  always_comb begin
    alu_dec_s   = 2'b00;
    flagw_dec_s = 2'b00;
    case (cmd_s)
      4'b0100: begin alu_dec_s = 2'b00; flagw_dec_s = {s_s, s_s};  end
      4'b0010: begin alu_dec_s = 2'b01; flagw_dec_s = {s_s, s_s};  end
      4'b0000: begin alu_dec_s = 2'b10; flagw_dec_s = {s_s, 1'b0}; end
      4'b1100: begin alu_dec_s = 2'b11; flagw_dec_s = {s_s, 1'b0}; end
      default: begin alu_dec_s = 2'b00; flagw_dec_s = 2'b00;       end
    endcase
  end

  // Next-state selection and per-state datapath controls
  always_comb begin
    next_s      = S_FETCH;
    pcw_fetch_s = 1'b0;
    branch_s    = 1'b0;
    regw_s      = 1'b0;
    memw_s      = 1'b0;
    irwrite_s   = 1'b0;
    adrsrc_s    = 1'b0;
    alusrca_s   = 1'b0;
    alusrcb_s   = 2'b00;
    resultsrc_s = 2'b00;
    aluctl_s    = 2'b00;
    flagw_s     = 2'b00;
    case (state_s)
      S_FETCH: begin
        next_s      = S_DECODE;
        pcw_fetch_s = 1'b1;
        irwrite_s   = 1'b1;
        alusrca_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
      end
      S_DECODE: begin
        alusrca_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
        case (op_s)
          2'b00:   next_s = i_s ? S_EXECUTEI : S_EXECUTER;
          2'b01:   next_s = S_MEMADR;
          2'b10:   next_s = S_BRANCH;
          default: next_s = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        next_s    = l_s ? S_MEMREAD : S_MEMWRITE;
        alusrcb_s = 2'b01;
      end
      S_MEMREAD: begin
        next_s   = S_MEMWB;
        adrsrc_s = 1'b1;
      end
      S_MEMWB: begin
        resultsrc_s = 2'b01;
        regw_s      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_s = 1'b1;
        memw_s   = 1'b1;
      end
      S_EXECUTER: begin
        next_s   = S_ALUWB;
        aluctl_s = alu_dec_s;
        flagw_s  = flagw_dec_s;
      end
      S_EXECUTEI: begin
        next_s    = S_ALUWB;
        alusrcb_s = 2'b01;
        aluctl_s  = alu_dec_s;
        flagw_s   = flagw_dec_s;
      end
      S_ALUWB: begin
        regw_s = 1'b1;
      end
      S_BRANCH: begin
        alusrcb_s   = 2'b01;
        resultsrc_s = 2'b10;
        branch_s    = 1'b1;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Condition-code check against the stored NZCV flags
  always_comb begin
    condex_s = 1'b0;
    case (cond_s)
      4'b0000: condex_s = flags_r[2];
      4'b0001: condex_s = ~flags_r[2];
      4'b0010: condex_s = flags_r[1];
      4'b0011: condex_s = ~flags_r[1];
      4'b0100: condex_s = flags_r[3];
      4'b0101: condex_s = ~flags_r[3];
      4'b0110: condex_s = flags_r[0];
      4'b0111: condex_s = ~flags_r[0];
      4'b1000: condex_s = flags_r[1] & ~flags_r[2];
      4'b1001: condex_s = ~flags_r[1] | flags_r[2];
      4'b1010: condex_s = ~(flags_r[3] ^ flags_r[0]);
      4'b1011: condex_s = flags_r[3] ^ flags_r[0];
      4'b1100: condex_s = ~flags_r[2] & ~(flags_r[3] ^ flags_r[0]);
      4'b1101: condex_s = flags_r[2] | (flags_r[3] ^ flags_r[0]);
      4'b1110: condex_s = 1'b1;
      default: condex_s = 1'b0;
    endcase
  end

  // Latch the condition outcome at the end of DECODE for the rest of the instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      condexl_r <= 1'b0;
    end else if (state_s == S_DECODE) begin
      condexl_r <= condex_s;
    end
  end

  // NZCV register: N,Z and C,V halves load independently when the instruction executes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r <= 4'b0000;
    end else begin
      if (flagw_s[1] & condexl_r) begin
        flags_r[3:2] <= bus.ALUFlags[3:2];
      end
      if (flagw_s[0] & condexl_r) begin
        flags_r[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // Write enables are held low for as long as reset is asserted
  assign bus.PCWrite    = reset & (pcw_fetch_s | (branch_s & condexl_r));
  assign bus.MemWrite   = reset & memw_s & condexl_r;
  assign bus.RegWrite   = reset & regw_s & condexl_r;
  assign bus.IRWrite    = reset & irwrite_s;
  assign bus.AdrSrc     = adrsrc_s;
  assign bus.ALUSrcA    = alusrca_s;
  assign bus.ALUSrcB    = alusrcb_s;
  assign bus.ResultSrc  = resultsrc_s;
  assign bus.ALUControl = aluctl_s;
  assign bus.ImmSrc     = op_s;
  assign bus.RegSrc     = {(op_s == 2'b01), (op_s == 2'b10)};

endmodule
